// File: rtl/dm_ext.sv
// dm_ext: data memory with byte/half/word access, sign/zero extension,
// req/ready handshake, WAIT wait-states and misalignment rejection.
// Ports: clk, rst (async, active-high), req, we, addr, size, sign_ext,
// in_d -> out_d (load result), ready (1-cycle pulse), misalign.
module dm_ext #(
  parameter int ADDR_W = 12,
  parameter int WAIT   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [31:0]       in_d,
  output logic [31:0]       out_d,
  output logic              ready,
  output logic              misalign
);

  localparam int DEPTH = 1 << (ADDR_W - 2);
  localparam logic [3:0] WAIT_C = 4'(WAIT);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic mis_q, mis_nx;

  logic              we_q;
  logic              sx_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic [31:0]       d_q;

  logic              take;
  logic              acc;
  logic              a_we;
  logic              a_sx;
  logic [ADDR_W-1:0] a_addr;
  logic [1:0]        a_size;
  logic [31:0]       a_d;

  logic [31:0] mem [DEPTH];
  logic [31:0] word;
  logic [31:0] ld_val;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [7:0]  bsel;
  logic [15:0] hsel;
  logic        mis_in;

  assign mis_in = (size == 2'b11)
                | ((size == 2'b01) & addr[0])
                | ((size == 2'b10) & (addr[1:0] != 2'b00));

  // Control: the access uses live inputs only on the zero-wait
  // accepting edge; otherwise the latched copy is used.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    mis_nx   = mis_q;
    take     = 1'b0;
    acc      = 1'b0;
    a_we     = we_q;
    a_sx     = sx_q;
    a_addr   = addr_q;
    a_size   = size_q;
    a_d      = d_q;
    unique case (state)
      IDLE: begin
        if (req) begin
          take = 1'b1;
          if (mis_in) begin
            mis_nx   = 1'b1;
            state_nx = DONE;
          end else if (WAIT == 0) begin
            acc      = 1'b1;
            a_we     = we;
            a_sx     = sign_ext;
            a_addr   = addr;
            a_size   = size;
            a_d      = in_d;
            state_nx = DONE;
          end else begin
            cnt_nx   = WAIT_C;
            state_nx = BUSY;
          end
        end
      end
      BUSY: begin
        cnt_nx = cnt - 4'd1;
        if (cnt == 4'd1) begin
          acc      = 1'b1;
          state_nx = DONE;
        end
      end
      DONE: begin
        state_nx = IDLE;
        mis_nx   = 1'b0;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Lane selection (little-endian)
  always_comb begin
    word = mem[a_addr[ADDR_W-1:2]];
    bsel = word[{a_addr[1:0], 3'b000} +: 8];
    hsel = a_addr[1] ? word[31:16] : word[15:0];
    ld_val = word;
    wdata  = a_d;
    be     = 4'b1111;
    unique case (a_size)
      2'b00: begin
        ld_val = {{24{a_sx & bsel[7]}}, bsel};
        wdata  = {4{a_d[7:0]}};
        be     = 4'b0001 << a_addr[1:0];
      end
      2'b01: begin
        ld_val = {{16{a_sx & hsel[15]}}, hsel};
        wdata  = {2{a_d[15:0]}};
        be     = a_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      mis_q  <= 1'b0;
      out_d  <= 32'd0;
      we_q   <= 1'b0;
      sx_q   <= 1'b0;
      addr_q <= '0;
      size_q <= 2'b00;
      d_q    <= 32'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      mis_q <= mis_nx;
      if (take) begin
        we_q   <= we;
        sx_q   <= sign_ext;
        addr_q <= addr;
        size_q <= size;
        d_q    <= in_d;
      end
      if (acc && !a_we) out_d <= ld_val;
    end
  end

  // Storage is never reset; rst also blocks a write on a reset edge.
  always_ff @(posedge clk) begin
    if (acc && a_we && !rst) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[a_addr[ADDR_W-1:2]][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign ready    = (state == DONE);
  assign misalign = (state == DONE) & mis_q;

endmodule

// File: tb/tb_dm_ext.sv
// tb_dm_ext: directed bench for dm_ext with instances at WAIT=0/1/3.
// The WAIT=1 instance is checked every cycle against a byte-level model.
module tb_dm_ext;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0;
  logic        req1 = 1'b0;
  logic        req3 = 1'b0;
  logic        we = 1'b0;
  logic [11:0] addr = 12'd0;
  logic [1:0]  size = 2'd0;
  logic        sx = 1'b0;
  logic [31:0] in_d = 32'd0;

  logic [31:0] od0, od1, od3;
  logic        rdy0, rdy1, rdy3;
  logic        mis0, mis1, mis3;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dm_ext #(.ADDR_W(12), .WAIT(0)) u0 (
    .clk(clk), .rst(rst), .req(req0), .we(we), .addr(addr),
    .size(size), .sign_ext(sx), .in_d(in_d), .out_d(od0),
    .ready(rdy0), .misalign(mis0)
  );

  dm_ext #(.ADDR_W(12), .WAIT(1)) u1 (
    .clk(clk), .rst(rst), .req(req1), .we(we), .addr(addr),
    .size(size), .sign_ext(sx), .in_d(in_d), .out_d(od1),
    .ready(rdy1), .misalign(mis1)
  );

  dm_ext #(.ADDR_W(12), .WAIT(3)) u3 (
    .clk(clk), .rst(rst), .req(req3), .we(we), .addr(addr),
    .size(size), .sign_ext(sx), .in_d(in_d), .out_d(od3),
    .ready(rdy3), .misalign(mis3)
  );

  // Model of the WAIT=1 instance: byte-addressed memory plus
  // edge-index arithmetic for accept / access / ready timing.
  localparam int W1 = 1;
  logic [7:0]  mm [4096];
  int          n = 0;
  int          next_free = 0;
  int          rdy_at = -1;
  int          acc_at = -1;
  bit          m_mis = 0;
  logic [31:0] exp_out = 32'd0;
  bit          p_we;
  logic [11:0] p_a;
  logic [1:0]  p_s;
  bit          p_x;
  logic [31:0] p_d;
  bit          chk_en = 0;

  initial for (int i = 0; i < 4096; i++) mm[i] = 8'd0;

  function automatic bit misal(logic [1:0] s, logic [11:0] a);
    return (s == 2'd3) || (s == 2'd1 && a[0])
        || (s == 2'd2 && a[1:0] != 2'd0);
  endfunction

  task automatic m_access();
    int nb;
    int base;
    logic [31:0] v;
    nb = 1 << p_s;
    base = int'(p_a);
    if (p_we) begin
      for (int i = 0; i < nb; i++) mm[base + i] = p_d[8*i +: 8];
    end else begin
      v = 32'd0;
      for (int i = 0; i < nb; i++) v[8*i +: 8] = mm[base + i];
      if (p_x && nb < 4 && v[8*nb-1])
        for (int i = nb; i < 4; i++) v[8*i +: 8] = 8'hFF;
      exp_out = v;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_at = -1;
      acc_at = -1;
      next_free = 0;
      exp_out = 32'd0;
      m_mis = 0;
    end else begin
      n++;
      if (req1 && n >= next_free) begin
        p_we = we; p_a = addr; p_s = size;
        p_x = sx; p_d = in_d;
        m_mis = misal(size, addr);
        if (m_mis) begin
          rdy_at = n;
          next_free = n + 2;
        end else begin
          rdy_at = n + W1;
          acc_at = n + W1;
          next_free = n + W1 + 2;
        end
      end
      if (n == acc_at) m_access();
    end
  end

  always @(negedge clk) begin
    bit er, em;
    if (chk_en && !rst) begin
      er = (n == rdy_at);
      em = er && m_mis;
      tests++;
      if (rdy1 !== er || mis1 !== em || od1 !== exp_out) begin
        fails++;
        $display("FAIL model_cmp edge=%0d ready=%b/%b misalign=%b/%b out_d=%h/%h (got/exp)",
                 n, rdy1, er, mis1, em, od1, exp_out);
      end
    end
  end

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  function automatic logic rdyf(int k);
    case (k)
      0: return rdy0;
      1: return rdy1;
      default: return rdy3;
    endcase
  endfunction

  function automatic logic misf(int k);
    case (k)
      0: return mis0;
      1: return mis1;
      default: return mis3;
    endcase
  endfunction

  function automatic logic [31:0] odf(int k);
    case (k)
      0: return od0;
      1: return od1;
      default: return od3;
    endcase
  endfunction

  task automatic set_req(int k, logic v);
    req0 = (k == 0) ? v : 1'b0;
    req1 = (k == 1) ? v : 1'b0;
    req3 = (k == 3) ? v : 1'b0;
  endtask

  // One access; inputs are scrambled after acceptance.
  task automatic op(input int k, input logic w, input logic [11:0] a,
                    input logic [1:0] s, input logic x,
                    input logic [31:0] d, input int lat,
                    input logic emis, input logic dchk,
                    input logic [31:0] ed, input string nm);
    int c;
    bit seen;
    @(negedge clk);
    we = w; addr = a; size = s; sx = x; in_d = d;
    set_req(k, 1'b1);
    seen = 0;
    c = 0;
    while (!seen && c < 20) begin
      @(negedge clk);
      set_req(k, 1'b0);
      if (c == 0) begin
        we = ~w; addr = ~a; sx = ~x; in_d = ~d;
      end
      c++;
      if (rdyf(k)) seen = 1;
    end
    chk({nm, "_lat"}, 32'(c), 32'(lat));
    chk({nm, "_mis"}, {31'd0, misf(k)}, {31'd0, emis});
    if (dchk) chk({nm, "_data"}, odf(k), ed);
  endtask

  task automatic thr(input int k, input int w, input int np_exp,
                     input string nm);
    int last;
    int np;
    int consec;
    logic prev;
    logic r;
    @(negedge clk);
    we = 1'b0; addr = 12'h010; size = 2'd2; sx = 1'b0;
    set_req(k, 1'b1);
    last = -1; np = 0; consec = 0; prev = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      r = rdyf(k);
      if (r && prev) consec++;
      if (r) begin
        if (last >= 0)
          chk({nm, "_interval"}, 32'(i - last), 32'(w + 2));
        last = i;
        np++;
      end
      prev = r;
    end
    set_req(k, 1'b0);
    chk({nm, "_pulses"}, 32'(np), 32'(np_exp));
    chk({nm, "_consec"}, 32'(consec), 32'd0);
    repeat (6) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_out_d", od1, 32'd0);
    chk("rst_ready", {31'd0, rdy1}, 32'd0);
    chk("rst_mis", {31'd0, mis1}, 32'd0);
    rst = 1'b0;
    chk_en = 1;

    // 1: word store / load
    op(1, 1, 12'h010, 2'd2, 0, 32'h12345678, 2, 0, 0, 0, "sw10");
    op(1, 0, 12'h010, 2'd2, 0, 0, 2, 0, 1, 32'h12345678, "lw10");
    // 2: byte lane
    op(1, 1, 12'h011, 2'd0, 0, 32'h00000080, 2, 0, 0, 0, "sb11");
    op(1, 0, 12'h011, 2'd0, 1, 0, 2, 0, 1, 32'hFFFFFF80, "lb11");
    op(1, 0, 12'h011, 2'd0, 0, 0, 2, 0, 1, 32'h00000080, "lbu11");
    op(1, 0, 12'h010, 2'd2, 0, 0, 2, 0, 1, 32'h12348078, "lw10b");
    // 3: half lane
    op(1, 1, 12'h012, 2'd1, 0, 32'h0000BEEF, 2, 0, 0, 0, "sh12");
    op(1, 0, 12'h012, 2'd1, 1, 0, 2, 0, 1, 32'hFFFFBEEF, "lh12");
    op(1, 0, 12'h012, 2'd1, 0, 0, 2, 0, 1, 32'h0000BEEF, "lhu12");
    op(1, 0, 12'h010, 2'd2, 0, 0, 2, 0, 1, 32'hBEEF8078, "lw10c");
    // 4: misaligned, out_d holds last load
    op(1, 0, 12'h013, 2'd2, 0, 0, 1, 1, 1, 32'hBEEF8078, "mis_lw");
    op(1, 1, 12'h011, 2'd1, 0, 32'hFFFF, 1, 1, 1, 32'hBEEF8078, "mis_sh");
    op(1, 0, 12'h010, 2'd3, 0, 0, 1, 1, 1, 32'hBEEF8078, "mis_rsv");
    op(1, 0, 12'h010, 2'd2, 0, 0, 2, 0, 1, 32'hBEEF8078, "lw10d");
    // 5: back-to-back throughput
    thr(1, 1, 7, "thr_w1");
    thr(0, 0, 10, "thr_w0");
    thr(3, 3, 4, "thr_w3");
    // 6: reset aborts a pending store
    op(3, 1, 12'h020, 2'd2, 0, 32'h0BADF00D, 4, 0, 0, 0, "w3_sw0");
    op(3, 0, 12'h020, 2'd2, 0, 0, 4, 0, 1, 32'h0BADF00D, "w3_lw0");
    @(negedge clk);
    we = 1'b1; addr = 12'h020; size = 2'd2; in_d = 32'hDEADBEEF;
    set_req(3, 1'b1);
    @(negedge clk);
    set_req(3, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_d", od3, 32'd0);
    chk("arst_ready", {31'd0, rdy3}, 32'd0);
    chk("arst_mis", {31'd0, mis3}, 32'd0);
    chk("arst_u1_out_d", od1, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    op(3, 0, 12'h020, 2'd2, 0, 0, 4, 0, 1, 32'h0BADF00D, "w3_lw1");
    op(1, 0, 12'h010, 2'd2, 0, 0, 2, 0, 1, 32'hBEEF8078, "lw10e");
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dm_ext.md
Name: dm_ext

Overview:
Parametrised successor to the word-only data memory. It adds byte, halfword and word access with sign or zero extension, a req/ready handshake, and configurable wait-state latency. Misaligned accesses are detected and flagged. It sits between the CPU MEM stage and the data RAM. The MEM stage stalls until ready pulses.

Parameters:
ADDR_W, 12, byte-address width; depth = 2^(ADDR_W-2) 32-bit words
WAIT, 1, extra wait-state cycles per aligned access (0..15)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset, asynchronous, active-high
req  input  1  access request; sampled only in IDLE
we  input  1  1 = store, 0 = load; latched with req
addr  input  ADDR_W  byte address; latched with req
size  input  2  00 byte, 01 half, 10 word, 11 reserved
sign_ext  input  1  loads: 1 = sign-extend, 0 = zero-extend
in_d  input  32  store data, right-justified; latched with req
out_d  output  32  load result, extended to 32 bits
ready  output  1  one-cycle completion pulse
misalign  output  1  high with ready when the access was rejected

Behaviour:
- Reset: clk and reset are fixed as one clock; reset is asynchronous and active-high.
  - rst=1 immediately forces state=IDLE, ready=0, misalign=0, out_d=0 and wait counter=0.
  - Memory contents are not cleared.
- Lane order is little-endian: byte at addr[1:0]=0 is bits 7:0; half at addr[1]=0 is bits 15:0.
- Misaligned when:
  - size=01 and addr[0]=1;
  - size=10 and addr[1:0]!=0;
  - size=11 (always).
- State machine: IDLE, BUSY, DONE.
  - IDLE, req=0: stay in IDLE.
  - IDLE, req=1: latch we, addr, size, sign_ext and in_d.
    - Misaligned -> DONE with misalign pending.
    - Else if WAIT=0 -> perform access at this edge, then go to DONE.
    - Else load counter=WAIT and go to BUSY.
  - BUSY: decrement counter each edge. At the edge where counter=1, perform the access and go to DONE.
  - DONE: ready=1, and misalign=1 if pending, for exactly this cycle. Next edge -> IDLE and clear both flags.
- Latency:
  - Aligned: ready is high in the cycle after edge E0+WAIT, where E0 is the accepting edge.
  - Misaligned: ready is high in the cycle after E0, independent of WAIT.
  - Peak throughput: one access per WAIT+2 cycles.
- Access point:
  - Stores write only the selected lanes, taken from in_d[7:0], [15:0] or [31:0]. Other lanes are unchanged.
  - Loads update out_d on the access edge. out_d holds until the next completed load.
  - Stores and misaligned accesses leave out_d unchanged.
- Misaligned accesses perform no memory write.
- req in BUSY or DONE is ignored. The requester must keep req high, or re-raise it, once the block is back in IDLE.
- Input changes after acceptance have no effect. The latched copy is used.
- Reset mid-operation: a store not yet performed at the rst edge is aborted and memory is unchanged.
- Address space is exactly the depth, so there is no out-of-range case. addr wraps naturally.

Test Plan:
1. WAIT=1, reset, then sw 0x12345678 @0x010 -> ready pulses in cycle after 2nd edge, misalign=0. Then lw @0x010 -> out_d=0x12345678 with ready.
2. sb in_d=0x00000080 @0x011 -> lb sign_ext=1 @0x011 gives 0xFFFFFF80; lbu gives 0x00000080; lw @0x010 gives 0x12348078.
3. sh 0x0000BEEF @0x012 -> lh gives 0xFFFFBEEF; lhu gives 0x0000BEEF; lw @0x010 gives 0xBEEF8078.
4. lw @0x013, then sh @0x011, then size=11 @0x010:
   - each gives ready=1 and misalign=1 one cycle after accept;
   - out_d unchanged;
   - subsequent lw @0x010 still 0xBEEF8078.
5. req held high for 20 cycles, WAIT=1 (lw @0x010) -> ready pulses exactly every 3 cycles, never two consecutive cycles. Repeat with WAIT=0 (every 2 cycles) and WAIT=3 (every 5 cycles).
6. sw 0xDEADBEEF @0x020 with WAIT=3, rst pulsed during BUSY:
   - out_d=0, ready=0 and misalign=0 asynchronously;
   - after release, lw @0x020 returns the pre-write value, not 0xDEADBEEF.
